sd_init_ctrl: RTL and testbench

SPI-mode SD card initialization sequencer. It drives the card through the power-up sequence: dummy clocks, CMD0, CMD8, then repeated CMD55/ACMD41 until the card leaves idle. It sits between the host top level and the SD pins, and its `state_o` encoding is the one the bench card model keys on. Once initialization finishes, it hands the bus to the data-transfer logic through `init_o`.

---
 rtl/sd_init_ctrl.sv | 272 +++++++++++++++++++++++++++
 tb/tb_sd_init_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_init_ctrl.sv
// SPI-mode SD card power-up sequencer: dummy clocks, CMD0, CMD8, then CMD55/ACMD41
// until the card leaves idle. All pin outputs are registered.
module sd_init_ctrl #(
    parameter int unsigned DUMMY_CLKS   = 80,
    parameter int unsigned WAIT_GAP     = 8,
    parameter int unsigned RESP_TIMEOUT = 255,
    parameter int unsigned CMD0_RETRY   = 8,
    parameter int unsigned ACMD41_RETRY = 1023
) (
    input  logic       sd_clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       sd_miso,
    output logic       sd_cs_n,
    output logic       sd_mosi,
    output logic [3:0] state_o,
    output logic       init_o,
    output logic       init_fail_o,
    output logic       card_v2_o
);

    typedef enum logic [3:0] {
        StIdle       = 4'd0,
        StSendCmd0   = 4'd1,
        StWait01     = 4'd2,
        StWaitB      = 4'd3,
        StSendCmd8   = 4'd4,
        StWaitA      = 4'd5,
        StSendCmd55  = 4'd6,
        StSendAcmd41 = 4'd7,
        StInitDone   = 4'd8,
        StInitFail   = 4'd9,
        StDummy      = 4'd10
    } state_e;

    localparam logic [47:0] FrameCmd0   = 48'h40_00000000_95;
    localparam logic [47:0] FrameCmd8   = 48'h48_000001AA_87;
    localparam logic [47:0] FrameCmd55  = 48'h77_00000000_65;
    localparam logic [47:0] FrameAcmd41 = 48'h69_40000000_77;

    function automatic logic [47:0] frame_of(input state_e s);
        case (s)
            StSendCmd0:   frame_of = FrameCmd0;
            StSendCmd8:   frame_of = FrameCmd8;
            StSendCmd55:  frame_of = FrameCmd55;
            StSendAcmd41: frame_of = FrameAcmd41;
            default:      frame_of = '1;
        endcase
    endfunction

    state_e      state_q, state_d;
    state_e      next_cmd_q, next_cmd_d;
    logic [47:0] sh_q, sh_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] cnt_q, cnt_d;
    logic [38:0] resp_q, resp_d;
    logic        started_q, started_d;
    logic        rx_q, rx_d;
    logic [15:0] cmd0_cnt_q, cmd0_cnt_d;
    logic [15:0] acmd_cnt_q, acmd_cnt_d;
    logic        card_v2_q, card_v2_d;
    logic        sd_cs_n_q, sd_cs_n_d;
    logic        sd_mosi_q, sd_mosi_d;

    logic        load, send_done, rsp_done, rsp_tmo, in_send, in_resp;
    logic [39:0] rsp_word;
    logic [5:0]  resp_len;
    logic [47:0] frame;

    always_comb begin
        state_d    = state_q;
        next_cmd_d = next_cmd_q;
        sh_d       = sh_q;
        bit_cnt_d  = bit_cnt_q;
        cnt_d      = cnt_q;
        resp_d     = resp_q;
        started_d  = started_q;
        rx_d       = rx_q;
        cmd0_cnt_d = cmd0_cnt_q;
        acmd_cnt_d = acmd_cnt_q;
        card_v2_d  = card_v2_q;
        sd_mosi_d  = 1'b1;
        load       = 1'b0;
        send_done  = 1'b0;
        rsp_done   = 1'b0;
        rsp_tmo    = 1'b0;
        frame      = '1;
        rsp_word   = {resp_q, sd_miso};
        resp_len   = (state_q == StWaitA) ? 6'd40 : 6'd8;
        in_send    = (state_q inside {StSendCmd0, StSendCmd8, StSendCmd55, StSendAcmd41}) && !rx_q;
        in_resp    = (state_q inside {StWait01, StWaitA}) ||
                     ((state_q inside {StSendCmd55, StSendAcmd41}) && rx_q);

        // bit_cnt_q == 48 means bit 0 is on the wire this cycle
        if (in_send) begin
            if (bit_cnt_q == 6'd48) begin
                send_done = 1'b1;
                bit_cnt_d = 6'd0;
                cnt_d     = 16'd0;
                started_d = 1'b0;
            end else begin
                sd_mosi_d = sh_q[47];
                sh_d      = {sh_q[46:0], 1'b1};
                bit_cnt_d = bit_cnt_q + 6'd1;
            end
        end

        if (in_resp) begin
            if (!started_q) begin
                if (!sd_miso) begin
                    started_d = 1'b1;
                    resp_d    = rsp_word[38:0];
                    bit_cnt_d = 6'd1;
                end else begin
                    cnt_d   = cnt_q + 16'd1;
                    rsp_tmo = (cnt_q + 16'd1 == 16'(RESP_TIMEOUT));
                end
            end else begin
                resp_d    = rsp_word[38:0];
                bit_cnt_d = bit_cnt_q + 6'd1;
                rsp_done  = (bit_cnt_q + 6'd1 == resp_len);
            end
        end

        case (state_q)
            StIdle, StInitDone, StInitFail: begin
                if (start) begin
                    state_d    = StDummy;
                    cnt_d      = 16'd0;
                    cmd0_cnt_d = 16'd0;
                    acmd_cnt_d = 16'd0;
                    card_v2_d  = 1'b0;
                end
            end
            StDummy: begin
                if (cnt_q == 16'(DUMMY_CLKS - 1)) begin
                    state_d    = StSendCmd0;
                    load       = 1'b1;
                    cmd0_cnt_d = cmd0_cnt_q + 16'd1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StSendCmd0: if (send_done) state_d = StWait01;
            StWait01: begin
                if (rsp_done && rsp_word[7:0] == 8'h01) begin
                    state_d    = StWaitB;
                    next_cmd_d = StSendCmd8;
                    cnt_d      = 16'd0;
                end else if (rsp_done || rsp_tmo) begin
                    if (cmd0_cnt_q < 16'(CMD0_RETRY)) begin
                        state_d    = StSendCmd0;
                        load       = 1'b1;
                        cmd0_cnt_d = cmd0_cnt_q + 16'd1;
                    end else begin
                        state_d = StInitFail;
                    end
                end
            end
            StWaitB: begin
                if (cnt_q == 16'(WAIT_GAP - 1)) begin
                    state_d = next_cmd_q;
                    load    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StSendCmd8: if (send_done) state_d = StWaitA;
            StWaitA: begin
                if (rsp_done) begin
                    if (rsp_word[39:32] == 8'h01 && rsp_word[11:0] == 12'h1AA) begin
                        card_v2_d  = 1'b1;
                        state_d    = StWaitB;
                        next_cmd_d = StSendCmd55;
                        cnt_d      = 16'd0;
                    end else if (rsp_word[39:32] == 8'h05) begin
                        card_v2_d  = 1'b0;
                        state_d    = StWaitB;
                        next_cmd_d = StSendCmd55;
                        cnt_d      = 16'd0;
                    end else begin
                        state_d = StInitFail;
                    end
                end else if (rsp_tmo) begin
                    state_d = StInitFail;
                end
            end
            StSendCmd55: begin
                if (send_done) begin
                    rx_d = 1'b1;
                end else if (rsp_done && rsp_word[7:1] == 7'd0) begin
                    state_d = StSendAcmd41;
                    load    = 1'b1;
                end else if (rsp_done || rsp_tmo) begin
                    state_d = StInitFail;
                end
            end
            StSendAcmd41: begin
                if (send_done) begin
                    rx_d = 1'b1;
                end else if (rsp_done && rsp_word[7:0] == 8'h00) begin
                    state_d = StInitDone;
                end else if (rsp_done && rsp_word[7:0] == 8'h01) begin
                    acmd_cnt_d = acmd_cnt_q + 16'd1;
                    if (acmd_cnt_q + 16'd1 < 16'(ACMD41_RETRY)) begin
                        state_d    = StWaitB;
                        next_cmd_d = StSendCmd55;
                        cnt_d      = 16'd0;
                    end else begin
                        state_d = StInitFail;
                    end
                end else if (rsp_done || rsp_tmo) begin
                    state_d = StInitFail;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) rx_d = 1'b0;

        // First send cycle already presents bit 47
        if (load) begin
            frame     = frame_of(state_d);
            sd_mosi_d = frame[47];
            sh_d      = {frame[46:0], 1'b1};
            bit_cnt_d = 6'd1;
            rx_d      = 1'b0;
        end

        sd_cs_n_d = state_d inside {StIdle, StDummy, StInitFail};
    end

    always_ff @(posedge sd_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            next_cmd_q <= StSendCmd0;
            sh_q       <= '1;
            bit_cnt_q  <= 6'd0;
            cnt_q      <= 16'd0;
            resp_q     <= '1;
            started_q  <= 1'b0;
            rx_q       <= 1'b0;
            cmd0_cnt_q <= 16'd0;
            acmd_cnt_q <= 16'd0;
            card_v2_q  <= 1'b0;
            sd_cs_n_q  <= 1'b1;
            sd_mosi_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            next_cmd_q <= next_cmd_d;
            sh_q       <= sh_d;
            bit_cnt_q  <= bit_cnt_d;
            cnt_q      <= cnt_d;
            resp_q     <= resp_d;
            started_q  <= started_d;
            rx_q       <= rx_d;
            cmd0_cnt_q <= cmd0_cnt_d;
            acmd_cnt_q <= acmd_cnt_d;
            card_v2_q  <= card_v2_d;
            sd_cs_n_q  <= sd_cs_n_d;
            sd_mosi_q  <= sd_mosi_d;
        end
    end

    assign sd_cs_n     = sd_cs_n_q;
    assign sd_mosi     = sd_mosi_q;
    assign state_o     = state_q;
    assign init_o      = (state_q == StInitDone);
    assign init_fail_o = (state_q == StInitFail);
    assign card_v2_o   = card_v2_q;

endmodule

// File: tb/tb_sd_init_ctrl.sv
// Bench for sd_init_ctrl: a behavioural SPI card model answers commands it decodes from
// sd_mosi, driven by a table of card behaviours plus a few hand-written sequences.
module tb_sd_init_ctrl;

    localparam logic [47:0] F_CMD0   = 48'h400000000095;
    localparam logic [47:0] F_CMD8   = 48'h48000001AA87;
    localparam logic [47:0] F_CMD55  = 48'h770000000065;
    localparam logic [47:0] F_ACMD41 = 48'h694000000077;

    logic       sd_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       miso_r = 1'b1;
    logic       sd_cs_n, sd_mosi, init_o, init_fail_o, card_v2_o;
    logic [3:0] state_o;

    sd_init_ctrl #(
        .DUMMY_CLKS  (80),
        .WAIT_GAP    (8),
        .RESP_TIMEOUT(255),
        .CMD0_RETRY  (8),
        .ACMD41_RETRY(3)
    ) dut (
        .sd_clk     (sd_clk),
        .rst_n      (rst_n),
        .start      (start),
        .sd_miso    (miso_r),
        .sd_cs_n    (sd_cs_n),
        .sd_mosi    (sd_mosi),
        .state_o    (state_o),
        .init_o     (init_o),
        .init_fail_o(init_fail_o),
        .card_v2_o  (card_v2_o)
    );

    always #5 sd_clk = ~sd_clk;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Card behaviour knobs, written only by the main sequence
    logic [7:0]  cfg_cmd0_r1 = 8'h01;  // 8'hFF: never answer CMD0
    logic [39:0] cfg_r7 = 40'h01000001AA;
    bit          cfg_r7_short = 1'b0;  // answer CMD8 with R1 only
    int          cfg_busy = 0;         // ACMD41 answers of 0x01 before 0x00
    bit          card_clr = 1'b0;

    logic [47:0] win;
    logic        txq[$];
    int          n_cmd0, n_acmd, busy_left;

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) txq.push_back(b[i]);
    endtask

    // Card: sees MOSI and drives MISO on the falling edge
    initial begin
        win = '1;
        forever begin
            @(negedge sd_clk);
            if (!rst_n || card_clr) begin
                txq.delete();
                win = '1;
                miso_r = 1'b1;
                if (card_clr) begin
                    n_cmd0 = 0;
                    n_acmd = 0;
                    busy_left = cfg_busy;
                end
            end else begin
                miso_r = (txq.size() > 0) ? txq.pop_front() : 1'b1;
                if (!sd_cs_n) begin
                    win = {win[46:0], sd_mosi};
                    if (win == F_CMD0) begin
                        n_cmd0++;
                        win = '1;
                        if (cfg_cmd0_r1 != 8'hFF) begin
                            txq.push_back(1'b1);
                            push_byte(cfg_cmd0_r1);
                        end
                    end else if (win == F_CMD8) begin
                        win = '1;
                        txq.push_back(1'b1);
                        if (cfg_r7_short) push_byte(cfg_r7[39:32]);
                        else for (int i = 39; i >= 0; i--) txq.push_back(cfg_r7[i]);
                    end else if (win == F_CMD55) begin
                        win = '1;
                        txq.push_back(1'b1);
                        push_byte(8'h01);
                    end else if (win == F_ACMD41) begin
                        win = '1;
                        n_acmd++;
                        txq.push_back(1'b1);
                        if (busy_left > 0) begin
                            busy_left--;
                            push_byte(8'h01);
                        end else begin
                            push_byte(8'h00);
                        end
                    end
                end
            end
        end
    end

    // State trace and run lengths of wait_01 / waitb
    bit         rec_en = 1'b0;
    logic [3:0] trace[$];
    int         t2_len[$];
    int         t3_len[$];
    logic [3:0] last_st;
    int         run_len;

    initial begin
        forever begin
            @(negedge sd_clk);
            if (!rec_en) begin
                trace.delete();
                t2_len.delete();
                t3_len.delete();
                last_st = state_o;
                run_len = 0;
            end else if (state_o != last_st) begin
                if (last_st == 4'd2) t2_len.push_back(run_len);
                if (last_st == 4'd3) t3_len.push_back(run_len);
                trace.push_back(state_o);
                last_st = state_o;
                run_len = 1;
            end else begin
                run_len++;
            end
        end
    end

    typedef struct {
        string       name;
        logic [7:0]  cmd0_r1;
        logic [39:0] r7;
        bit          r7_short;
        int          busy;
        logic [3:0]  exp_state;
        bit          exp_v2;
        int          exp_cmd0;
        int          exp_acmd;
        int          exp_t2;  // first wait_01 length, 0 = not checked
    } vec_t;

    vec_t vecs[9];

    task automatic prepare(input logic [7:0] c0, input logic [39:0] r7, input bit sh,
                           input int busy);
        cfg_cmd0_r1 = c0;
        cfg_r7 = r7;
        cfg_r7_short = sh;
        cfg_busy = busy;
        @(negedge sd_clk);
        #2;
        card_clr = 1'b1;
        rec_en = 1'b0;
        @(negedge sd_clk);
        @(negedge sd_clk);
        #2;
        card_clr = 1'b0;
        rec_en = 1'b1;
    endtask

    task automatic pulse_start();
        @(negedge sd_clk);
        start = 1'b1;
        @(negedge sd_clk);
        start = 1'b0;
    endtask

    task automatic wait_term(input string name, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge sd_clk);
            if (state_o == 4'd8 || state_o == 4'd9) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, ".reached_terminal"}, 64'(ok), 64'd1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] bits;
        logic [3:0]  exp_tr[16];
        int          bad;
        bit          ok;

        vecs[0] = '{"normal",    8'h01, 40'h01000001AA, 1'b0, 2,  4'd8, 1'b1, 1, 3, 0};
        vecs[1] = '{"v1_card",   8'h01, 40'h05FFFFFFFF, 1'b1, 0,  4'd8, 1'b0, 1, 1, 0};
        vecs[2] = '{"echo_1ab",  8'h01, 40'h01000001AB, 1'b0, 0,  4'd9, 1'b0, 1, 0, 0};
        vecs[3] = '{"busy_3",    8'h01, 40'h01000001AA, 1'b0, 99, 4'd9, 1'b1, 1, 3, 0};
        vecs[4] = '{"cmd0_none", 8'hFF, 40'h01000001AA, 1'b0, 0,  4'd9, 1'b0, 8, 0, 255};
        vecs[5] = '{"cmd0_00",   8'h00, 40'h01000001AA, 1'b0, 0,  4'd9, 1'b0, 8, 0, 0};
        vecs[6] = '{"r7_r1_09",  8'h01, 40'h09000001AA, 1'b0, 0,  4'd9, 1'b0, 1, 0, 0};
        vecs[7] = '{"ready_now", 8'h01, 40'h01000001AA, 1'b0, 0,  4'd8, 1'b1, 1, 1, 0};
        vecs[8] = '{"volt_2aa",  8'h01, 40'h01000002AA, 1'b0, 0,  4'd9, 1'b0, 1, 0, 0};
        exp_tr = '{4'd10, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd3, 4'd6, 4'd7, 4'd3, 4'd6, 4'd7,
                   4'd3, 4'd6, 4'd7, 4'd8};

        // Reset values
        repeat (3) @(negedge sd_clk);
        check("rst.state", 64'(state_o), 64'd0);
        check("rst.cs_n", 64'(sd_cs_n), 64'd1);
        check("rst.mosi", 64'(sd_mosi), 64'd1);
        check("rst.init", 64'(init_o), 64'd0);
        check("rst.fail", 64'(init_fail_o), 64'd0);
        check("rst.v2", 64'(card_v2_o), 64'd0);
        #2 rst_n = 1'b1;

        // Full power-up with the dummy phase and CMD0 frame checked bit by bit
        prepare(8'h01, 40'h01000001AA, 1'b0, 2);
        pulse_start();
        bad = 0;
        for (int i = 0; i < 80; i++) begin
            if (state_o != 4'd10 || sd_cs_n != 1'b1 || sd_mosi != 1'b1) bad++;
            @(negedge sd_clk);
        end
        check("dummy.bad_cycles", 64'(bad), 64'd0);
        bad = 0;
        for (int i = 0; i < 48; i++) begin
            bits[47-i] = sd_mosi;
            if (state_o != 4'd1 || sd_cs_n != 1'b0) bad++;
            @(negedge sd_clk);
        end
        check("cmd0.bits", 64'(bits), 64'(F_CMD0));
        check("cmd0.bad_cycles", 64'(bad), 64'd0);
        wait_term("seq", 20000);
        check("seq.trace_len", 64'(trace.size()), 64'd16);
        for (int i = 0; i < 16; i++)
            check($sformatf("seq.trace[%0d]", i), 64'(trace.size() > i ? trace[i] : 4'hF),
                  64'(exp_tr[i]));
        check("seq.waitb_len", 64'(t3_len.size() > 0 ? t3_len[0] : -1), 64'd8);
        check("seq.init", 64'(init_o), 64'd1);
        check("seq.v2", 64'(card_v2_o), 64'd1);

        // Card behaviour table, each run restarted from a terminal state
        foreach (vecs[k]) begin
            prepare(vecs[k].cmd0_r1, vecs[k].r7, vecs[k].r7_short, vecs[k].busy);
            pulse_start();
            check({vecs[k].name, ".restart_state"}, 64'(state_o), 64'd10);
            check({vecs[k].name, ".restart_v2"}, 64'(card_v2_o), 64'd0);
            wait_term(vecs[k].name, 20000);
            check({vecs[k].name, ".state"}, 64'(state_o), 64'(vecs[k].exp_state));
            check({vecs[k].name, ".init"}, 64'(init_o), 64'(vecs[k].exp_state == 4'd8));
            check({vecs[k].name, ".fail"}, 64'(init_fail_o), 64'(vecs[k].exp_state == 4'd9));
            check({vecs[k].name, ".cs_n"}, 64'(sd_cs_n), 64'(vecs[k].exp_state == 4'd9));
            check({vecs[k].name, ".mosi"}, 64'(sd_mosi), 64'd1);
            check({vecs[k].name, ".v2"}, 64'(card_v2_o), 64'(vecs[k].exp_v2));
            check({vecs[k].name, ".n_cmd0"}, 64'(n_cmd0), 64'(vecs[k].exp_cmd0));
            check({vecs[k].name, ".n_acmd41"}, 64'(n_acmd), 64'(vecs[k].exp_acmd));
            if (vecs[k].exp_t2 != 0)
                check({vecs[k].name, ".timeout_len"},
                      64'(t2_len.size() > 0 ? t2_len[0] : -1), 64'(vecs[k].exp_t2));
        end

        // Asynchronous reset in the middle of CMD8, then a clean rerun
        prepare(8'h01, 40'h01000001AA, 1'b0, 2);
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge sd_clk);
            if (state_o == 4'd4) begin
                ok = 1'b1;
                break;
            end
        end
        check("mid.reached_cmd8", 64'(ok), 64'd1);
        repeat (10) @(negedge sd_clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid.state", 64'(state_o), 64'd0);
        check("mid.cs_n", 64'(sd_cs_n), 64'd1);
        check("mid.mosi", 64'(sd_mosi), 64'd1);
        check("mid.init", 64'(init_o), 64'd0);
        check("mid.fail", 64'(init_fail_o), 64'd0);
        check("mid.v2", 64'(card_v2_o), 64'd0);
        repeat (3) @(negedge sd_clk);
        #2 rst_n = 1'b1;
        prepare(8'h01, 40'h01000001AA, 1'b0, 2);
        pulse_start();
        wait_term("rerun", 20000);
        check("rerun.first_state", 64'(trace.size() > 0 ? trace[0] : 4'hF), 64'd10);
        check("rerun.state", 64'(state_o), 64'd8);
        check("rerun.n_cmd0", 64'(n_cmd0), 64'd1);
        check("rerun.n_acmd41", 64'(n_acmd), 64'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
